// File: rtl/writeback_stage.sv
// LEGv8 write-back stage: buffers retiring results in a small FIFO, drives the regfile
// write port one entry per granted cycle, and offers a combinational forwarding lookup.
module writeback_stage #(
  parameter int WORD  = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic             in_mem_to_reg,
  input  logic [WORD-1:0]  in_alu_result,
  input  logic [WORD-1:0]  in_mem_data,
  input  logic             port_grant,
  output logic [4:0]       write_register,
  output logic [WORD-1:0]  write_data,
  output logic             reg_write,
  input  logic [4:0]       fwd_query_reg,
  output logic             fwd_hit,
  output logic [WORD-1:0]  fwd_data,
  output logic [CNT_W-1:0] retire_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]       fifo_rd_q   [DEPTH];
  logic [WORD-1:0]  fifo_data_q [DEPTH];
  logic             fifo_wen_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [4:0]       write_register_q;
  logic [WORD-1:0]  write_data_q;
  logic             reg_write_q;
  logic [CNT_W-1:0] retire_q;

  logic push, pop;

  assign in_ready = (count_q < (PTR_W + 1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count_q != '0) && port_grant;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset: the pointers alone decide which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= in_rd;
      fifo_data_q[wr_ptr_q] <= in_mem_to_reg ? in_mem_data : in_alu_result;
      fifo_wen_q[wr_ptr_q]  <= in_reg_write && (in_rd != 5'd31);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      write_register_q <= '0;
      write_data_q     <= '0;
      reg_write_q      <= 1'b0;
      retire_q         <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (pop) begin
        write_register_q <= fifo_rd_q[rd_ptr_q];
        write_data_q     <= fifo_data_q[rd_ptr_q];
        reg_write_q      <= fifo_wen_q[rd_ptr_q];
        retire_q         <= retire_q + CNT_W'(1);
      end else begin
        reg_write_q <= 1'b0;
      end
    end
  end

  assign write_register = write_register_q;
  assign write_data     = write_data_q;
  assign reg_write      = reg_write_q;
  assign retire_count   = retire_q;

  // Slot gi holds the entry of age gi counted from the head (0 = oldest).
  logic [DEPTH-1:0] slot_match;
  logic [WORD-1:0]  slot_data [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
    logic [PTR_W-1:0] idx;
    assign idx            = rd_ptr_q + PTR_W'(gi);
    assign slot_data[gi]  = fifo_data_q[idx];
    assign slot_match[gi] = ((PTR_W + 1)'(gi) < count_q) && fifo_wen_q[idx]
                            && (fifo_rd_q[idx] == fwd_query_reg);
  end

  // Scan oldest to youngest so the last match (youngest) overrides.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (reg_write_q && (write_register_q == fwd_query_reg)) begin
      fwd_hit  = 1'b1;
      fwd_data = write_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_match[i]) begin
        fwd_hit  = 1'b1;
        fwd_data = slot_data[i];
      end
    end
    if (fwd_query_reg == 5'd31) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end

endmodule
